// File: rtl/draw_sequencer_pkg.sv
// Shared types and value-range constants for the draw sequencer and its
// random-number source handshake.
package draw_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} draw_state_t;

    localparam int VALUE_W = 4;
    typedef logic [VALUE_W-1:0] value_t;

    localparam value_t VALUE_MIN = value_t'(1);
    localparam value_t VALUE_MAX = value_t'(11);

    function automatic logic is_legal(input value_t v);
        return (v >= VALUE_MIN) && (v <= VALUE_MAX);
    endfunction

endpackage

// File: rtl/draw_sequencer_if.sv
// Request/response link between the draw sequencer and the random-number source.
// rnd_req is a one-cycle request pulse; the source later raises rnd_ready for
// one cycle and rnd_value is meaningful only in that cycle. There is no backpressure.
interface draw_src_if;

    logic            rnd_req;
    logic            rnd_ready;
    draw_pkg::value_t rnd_value;

    modport master (
        output rnd_req,
        input  rnd_ready,
        input  rnd_value
    );

    modport slave (
        input  rnd_req,
        output rnd_ready,
        output rnd_value
    );

endinterface

// File: rtl/draw_sequencer_stats.sv
// Running sum / minimum / maximum over the accepted draws of one batch.
module draw_stats
    import draw_pkg::*;
#(
    parameter int SUM_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load_first,
    input  logic             en,
    input  value_t           value,
    output logic [SUM_W-1:0] sum,
    output value_t           min_value,
    output value_t           max_value
);

    logic [SUM_W-1:0] r_sum;
    value_t           r_min;
    value_t           r_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum <= '0;
            r_min <= '0;
            r_max <= '0;
        end else if (clr) begin
            r_sum <= '0;
            r_min <= '0;
            r_max <= '0;
        end else if (en) begin
            r_sum <= r_sum + SUM_W'(value);
            // The cleared extremes are not a real sample, so the first draw overwrites both.
            if (load_first) begin
                r_min <= value;
                r_max <= value;
            end else begin
                if (value < r_min) r_min <= value;
                if (value > r_max) r_max <= value;
            end
        end
    end

    assign sum       = r_sum;
    assign min_value = r_min;
    assign max_value = r_max;

endmodule

// File: rtl/draw_sequencer.sv
// Batch controller: requests N_DRAWS legal values from the random source,
// publishes each accepted draw and tracks sum/min/max plus error flags.
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int  N_DRAWS = 4,
    parameter int  TIMEOUT = 8,
    localparam int SUM_W   = $clog2(N_DRAWS * int'(VALUE_MAX) + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    draw_src_if.master        src,
    output logic              busy,
    output logic              draw_valid,
    output value_t            draw_value,
    output logic [3:0]        draw_index,
    output logic [SUM_W-1:0]  sum,
    output value_t            min_value,
    output value_t            max_value,
    output logic              batch_done,
    output logic              range_err,
    output logic              timeout_err,
    output draw_state_t       dbg_state
);

    localparam logic [3:0] LAST_IDX = 4'(N_DRAWS - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    draw_state_t r_state;
    draw_state_t w_next;
    logic [7:0]  r_tmo_cnt;
    logic [3:0]  r_idx;
    logic        r_draw_valid;
    value_t      r_draw_value;
    logic [3:0]  r_draw_index;
    logic        r_batch_done;
    logic        r_range_err;
    logic        r_timeout_err;

    logic w_launch;
    logic w_accept;
    logic w_reject;
    logic w_timeout;
    logic w_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_launch  = 1'b0;
        w_accept  = 1'b0;
        w_reject  = 1'b0;
        w_timeout = 1'b0;
        w_last    = (r_idx == LAST_IDX);
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_launch = 1'b1;
                    w_next   = REQ;
                end
            end
            REQ: w_next = WAIT;
            WAIT: begin
                if (src.rnd_ready) begin
                    if (is_legal(src.rnd_value)) begin
                        w_accept = 1'b1;
                        w_next   = w_last ? IDLE : REQ;
                    end else begin
                        w_reject = 1'b1;
                        w_next   = REQ;
                    end
                end else if (r_tmo_cnt == TMO_LAST) begin
                    // This is the TIMEOUT-th silent WAIT cycle.
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo_cnt     <= '0;
            r_idx         <= '0;
            r_draw_valid  <= 1'b0;
            r_draw_value  <= '0;
            r_draw_index  <= '0;
            r_batch_done  <= 1'b0;
            r_range_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_draw_valid <= w_accept;
            r_batch_done <= w_accept && w_last;
            if (r_state == REQ)
                r_tmo_cnt <= '0;
            else if (r_state == WAIT && !src.rnd_ready)
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            if (w_launch) begin
                r_idx         <= '0;
                r_draw_index  <= '0;
                r_range_err   <= 1'b0;
                r_timeout_err <= 1'b0;
            end
            // r_idx is the draw being attempted; draw_index reports the one just accepted.
            if (w_accept) begin
                r_draw_value <= src.rnd_value;
                r_draw_index <= r_idx;
                if (!w_last) r_idx <= r_idx + 4'd1;
            end
            if (w_reject)  r_range_err   <= 1'b1;
            if (w_timeout) r_timeout_err <= 1'b1;
        end
    end

    draw_stats #(
        .SUM_W (SUM_W)
    ) u_stats (
        .clk        (clk),
        .rst        (rst),
        .clr        (w_launch),
        .load_first (r_idx == 4'd0),
        .en         (w_accept),
        .value      (src.rnd_value),
        .sum        (sum),
        .min_value  (min_value),
        .max_value  (max_value)
    );

    assign src.rnd_req  = (r_state == REQ);
    assign busy         = (r_state != IDLE);
    assign dbg_state    = r_state;
    assign draw_valid   = r_draw_valid;
    assign draw_value   = r_draw_value;
    assign draw_index   = r_draw_index;
    assign batch_done   = r_batch_done;
    assign range_err    = r_range_err;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_draw_sequencer.sv
// Randomized bench for draw_sequencer: a response-list source, a batch-level
// reference model and a per-cycle scoreboard.
module tb_draw_sequencer;
    import draw_pkg::*;

    localparam int N_DRAWS = 4;
    localparam int TIMEOUT = 8;
    localparam int SUM_W   = $clog2(N_DRAWS * 11 + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    draw_src_if sif ();

    logic             busy;
    logic             draw_valid;
    value_t           draw_value;
    logic [3:0]       draw_index;
    logic [SUM_W-1:0] sum;
    value_t           min_value;
    value_t           max_value;
    logic             batch_done;
    logic             range_err;
    logic             timeout_err;
    draw_state_t      dbg_state;

    draw_sequencer #(
        .N_DRAWS (N_DRAWS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .src         (sif),
        .busy        (busy),
        .draw_valid  (draw_valid),
        .draw_value  (draw_value),
        .draw_index  (draw_index),
        .sum         (sum),
        .min_value   (min_value),
        .max_value   (max_value),
        .batch_done  (batch_done),
        .range_err   (range_err),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // source response list: value and latency (-1 = never answers) per request
    int src_vals[$];
    int src_lat[$];
    int ans_at = -1;
    int ans_val = 0;

    // scoreboard: {cycle[15:0], index[3:0], value[3:0]} per expected draw
    logic [23:0] exp_q[$];
    int req_q[$];
    int exp_sum, exp_min, exp_max;
    bit exp_rerr;
    int done_cyc, tmo_cyc, end_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_state();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_req", sif.rnd_req, 0);
        check_eq("rst_valid", draw_valid, 0);
        check_eq("rst_value", draw_value, 0);
        check_eq("rst_index", draw_index, 0);
        check_eq("rst_sum", sum, 0);
        check_eq("rst_min", min_value, 0);
        check_eq("rst_max", max_value, 0);
        check_eq("rst_done", batch_done, 0);
        check_eq("rst_rerr", range_err, 0);
        check_eq("rst_terr", timeout_err, 0);
        check_eq("rst_state", dbg_state, IDLE);
    endtask

    // Batch-level model: walk the response list attempt by attempt.
    // An attempt issued in cycle t with latency l answers in t+1+l and the
    // next request (and any accepted draw_valid) falls in t+2+l.
    task automatic build_model();
        int t;
        int idx;
        int v;
        int l;
        t = 1;
        idx = 0;
        exp_q.delete();
        req_q.delete();
        exp_sum = 0;
        exp_min = 0;
        exp_max = 0;
        exp_rerr = 0;
        done_cyc = -1;
        tmo_cyc = -1;
        for (int a = 0; a < 64; a++) begin
            req_q.push_back(t);
            if (a >= src_vals.size() || src_lat[a] < 0) begin
                tmo_cyc = t + TIMEOUT + 1;
                end_cyc = tmo_cyc;
                break;
            end
            v = src_vals[a];
            l = src_lat[a];
            if (v >= 1 && v <= 11) begin
                exp_q.push_back({16'(t + 2 + l), 4'(idx), 4'(v)});
                exp_sum += v;
                if (idx == 0) begin
                    exp_min = v;
                    exp_max = v;
                end else begin
                    if (v < exp_min) exp_min = v;
                    if (v > exp_max) exp_max = v;
                end
                idx++;
                if (idx == N_DRAWS) begin
                    done_cyc = t + 2 + l;
                    end_cyc = done_cyc;
                    break;
                end
            end else begin
                exp_rerr = 1;
            end
            t = t + 2 + l;
        end
    endtask

    // driver: source behaviour for one cycle (called just after the rising edge)
    task automatic src_step(input int cyc);
        int l;
        int v;
        if (cyc == ans_at) begin
            sif.rnd_ready = 1'b1;
            sif.rnd_value = value_t'(ans_val);
        end else begin
            sif.rnd_ready = 1'b0;
            sif.rnd_value = value_t'($urandom_range(0, 15));
        end
        if (sif.rnd_req === 1'b1 && src_lat.size() > 0) begin
            l = src_lat.pop_front();
            v = src_vals.pop_front();
            if (l >= 0) begin
                ans_at = cyc + 1 + l;
                ans_val = v;
            end
        end
    endtask

    // Caller has driven start=1 in cycle 0; runs until the batch's end cycle.
    task automatic run_batch(input bit hold_start, input bit chain_next);
        int cyc;
        cyc = 0;
        ans_at = -1;
        build_model();
        while (cyc < end_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
            start = hold_start;
            src_step(cyc);
            if (cyc == 1) begin
                check_eq("clr_sum", sum, 0);
                check_eq("clr_rerr", range_err, 0);
                check_eq("clr_terr", timeout_err, 0);
            end
            check_eq("busy", busy, 32'(cyc < end_cyc));
            if (sif.rnd_req === 1'b1)
                check_eq("req_cyc", cyc, req_q.size() > 0 ? req_q.pop_front() : -1);
            if (draw_valid === 1'b1)
                check_eq("draw", {16'(cyc), draw_index, draw_value},
                         exp_q.size() > 0 ? exp_q.pop_front() : 24'hFFFFFF);
            if (batch_done === 1'b1)
                check_eq("done_cyc", cyc, done_cyc);
            if (cyc == end_cyc) begin
                check_eq("end_done", batch_done, 32'(done_cyc >= 0));
                check_eq("end_sum", sum, exp_sum);
                check_eq("end_min", min_value, exp_min);
                check_eq("end_max", max_value, exp_max);
                check_eq("end_rerr", range_err, 32'(exp_rerr));
                check_eq("end_terr", timeout_err, 32'(tmo_cyc >= 0));
            end
        end
        check_eq("draws_left", exp_q.size(), 0);
        check_eq("reqs_left", req_q.size(), 0);
        start = chain_next;
    endtask

    // Idle cycles with random strobes on rnd_ready, which must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sif.rnd_ready = 1'($urandom_range(0, 1));
            sif.rnd_value = value_t'($urandom_range(0, 15));
            check_eq("idle_req", sif.rnd_req, 0);
            check_eq("idle_busy", busy, 0);
        end
        sif.rnd_ready = 1'b0;
    endtask

    task automatic gen_random(input int max_lat, input bit allow_tmo);
        int legal;
        int v;
        int l;
        legal = 0;
        src_vals.delete();
        src_lat.delete();
        while (legal < N_DRAWS) begin
            v = $urandom_range(0, 15);
            l = $urandom_range(0, max_lat);
            if (allow_tmo && $urandom_range(0, 11) == 0) l = -1;
            src_vals.push_back(v);
            src_lat.push_back(l);
            if (v >= 1 && v <= 11) legal++;
            if (l < 0) break;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        sif.rnd_ready = 1'b0;
        sif.rnd_value = '0;

        // reset, then release with no start
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state();
        idle(4);

        // nominal batch 3,5,7,9 with an immediate source
        src_vals = '{3, 5, 7, 9};
        src_lat  = '{0, 0, 0, 0};
        start = 1'b1;
        run_batch(1'b0, 1'b0);
        idle(3);

        // out-of-range values before draw 0
        src_vals = '{0, 12, 6, 2, 4, 8};
        src_lat  = '{0, 0, 0, 0, 0, 0};
        start = 1'b1;
        run_batch(1'b0, 1'b0);
        idle(3);

        // source never answers
        src_vals.delete();
        src_lat.delete();
        start = 1'b1;
        run_batch(1'b0, 1'b0);
        idle(2);

        // following batch clears timeout_err
        src_vals = '{11, 1, 10, 2};
        src_lat  = '{1, 0, 2, 0};
        start = 1'b1;
        run_batch(1'b0, 1'b0);
        idle(2);

        // start held through the batch, then relaunched in the batch_done cycle
        src_vals = '{8, 9, 15, 4, 5};
        src_lat  = '{0, 0, 0, 0, 0};
        start = 1'b1;
        run_batch(1'b1, 1'b1);
        src_vals = '{2, 2, 3, 1};
        src_lat  = '{0, 0, 0, 0};
        run_batch(1'b0, 1'b0);
        idle(2);

        // randomized batches
        for (int b = 0; b < 24; b++) begin
            gen_random(3, 1'b1);
            start = 1'b1;
            run_batch(1'($urandom_range(0, 1)), 1'b0);
            idle($urandom_range(1, 3));
        end

        // reset during WAIT of draw 2; its answer arrives while reset is low
        src_vals = '{4, 6, 8};
        src_lat  = '{0, 0, 1};
        ans_at = -1;
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            src_step(c);
        end
        check_eq("mid_busy_pre", busy, 1);
        check_eq("mid_sum_pre", sum, 10);
        check_eq("mid_index_pre", draw_index, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("mid_busy", busy, 0);
        check_eq("mid_req", sif.rnd_req, 0);
        check_eq("mid_sum", sum, 0);
        check_eq("mid_index", draw_index, 0);
        @(posedge clk);
        #1;
        src_step(7);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        sif.rnd_ready = 1'b0;
        check_eq("late_valid", draw_valid, 0);
        check_eq("late_busy", busy, 0);
        check_eq("late_sum", sum, 0);
        check_eq("late_state", dbg_state, IDLE);
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Batch controller that sits directly upstream of the random-number source. On a `start` pulse it issues `N_DRAWS` single-cycle requests over the source's request/ready/value handshake and validates each returned value against a legal range. It publishes every accepted draw with its index and keeps a running sum, minimum and maximum. Downstream display/control logic consumes the per-draw stream and the end-of-batch results.

## Interface
- `N_DRAWS`, 4: draws per batch, 1..15.
- `TIMEOUT`, 8: maximum WAIT cycles without `rnd_ready` before the batch aborts, 1..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; asynchronous, active-low.
- `start` in 1: begin a batch; sampled only in IDLE.
- `rnd_req` out 1: request to the source; high for exactly one cycle per attempt.
- `rnd_ready` in 1: source response strobe.
- `rnd_value` in 4: source value, valid when `rnd_ready` = 1.
- `busy` out 1: batch in progress.
- `draw_valid` out 1: one-cycle pulse per accepted draw.
- `draw_value` out 4: accepted value.
- `draw_index` out 4: index of the accepted draw, 0..N_DRAWS-1.
- `sum` out SUM_W: running sum of accepted draws. SUM_W = $clog2(N_DRAWS*11+1).
- `min_value`, `max_value` out 4: extremes of accepted draws.
- `batch_done` out 1: one-cycle pulse after the last accepted draw.
- `range_err` out 1: sticky; an out-of-range value was seen in this batch.
- `timeout_err` out 1: sticky; the batch aborted on timeout.

## Operation
- All outputs are registered, except `rnd_req` and `busy`, which decode the registered state.
- Reset value of every output is 0, and the state is IDLE.
- FSM states:
  - IDLE: `start` → REQ. Clears sum/min/max/index/range_err/timeout_err.
  - REQ: `rnd_req`=1; always → WAIT. Clears the timeout counter.
  - WAIT: behaviour on `rnd_ready`:
    - `rnd_ready`=1 with value in 1..11: accept the value.
    - `rnd_ready`=1 with value out of range (0 or 12..15): set `range_err`, discard the value, → REQ. The index is not advanced and there is no retry limit.
    - `rnd_ready`=0: the counter increments. When it reaches TIMEOUT, set `timeout_err`, → IDLE, and no `batch_done`.
- Accept: `draw_value`/`draw_index` load, `draw_valid` pulses next cycle, and `sum` += value.
  - First draw of the batch: `min_value` and `max_value` both load the value.
  - Later draws: each updates by compare.
  - If index = N_DRAWS-1: → IDLE, and `batch_done` pulses in the same cycle as the final `draw_valid`. Otherwise, `draw_index`+1 and → REQ.
- `busy` = (state ≠ IDLE).
- `start` while busy is ignored.
- `start` in the cycle `batch_done` is high is accepted, because the state is already IDLE.
- `rnd_ready` is ignored outside WAIT.
- Sum arithmetic is unsigned. SUM_W guarantees no overflow for legal values.
- Reset asserted mid-batch:
  - All registers return to their reset values immediately, without waiting for a clock edge.
  - `rnd_req` drops, and a pending response is discarded.
  - After reset release, the block does nothing until a new `start`.

## Timing
- `start` sampled high at the end of cycle 0: REQ in cycle 1, WAIT in cycle 2.
- The source answers one cycle after the request, so `rnd_ready` is high in cycle 2 and the value is captured at the end of cycle 2.
- `draw_valid` is high in cycle 3, the same cycle as the next REQ.
- Each draw takes 2 cycles with an immediate-ready source. The last `draw_valid` and `batch_done` fall in cycle 2·N_DRAWS+1, and `busy` is high in cycles 1..2·N_DRAWS.
- Timeout: `timeout_err` rises TIMEOUT+1 cycles after the REQ cycle, and `busy` falls in the same cycle.

## Structure
- Package `draw_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, REQ, WAIT} draw_state_t`
  - `VALUE_W`=4, `VALUE_MIN`=1, `VALUE_MAX`=11
  - a `value_t` typedef
- Sub-module `draw_stats`: sum/min/max accumulator.
  - Inputs: `clr`, `load_first`, `en`, `value`.
  - Outputs: `sum`, `min_value`, `max_value`.
  - Same clock and reset as the parent.
- The FSM, timeout counter and handshake live in `draw_sequencer`.

## Test plan
- **Reset:** drive `rst`=0 mid-run, then release → every output is 0, state is IDLE, and `rnd_req` stays 0 with no `start`.
- **Nominal batch:** N_DRAWS=4, source model returns 3,5,7,9 one cycle after each request → `draw_valid` in cycles 3,5,7,9 with index 0..3, `sum`=24, `min_value`=3, `max_value`=9, and `batch_done` in cycle 9.
- **Out-of-range values:** source returns 0, then 12, then 6 for draw 0 → `range_err`=1, three `rnd_req` pulses, one `draw_valid` with value 6 and index 0, and the batch completes normally.
- **Timeout:** TIMEOUT=8 and the source never answers → `timeout_err` rises in cycle 10, `busy` goes to 0, and `batch_done` never pulses. The next `start` clears `timeout_err`.
- **Back-to-back and ignored starts:** `start` held high for the whole batch → no restart while busy. `start` in the `batch_done` cycle launches a new batch with `sum` cleared to 0.
- **Reset mid-batch:** `rst` asserted during WAIT of draw 2 → `busy`, `rnd_req`, `sum` and `draw_index` are 0 before the next clock edge, and the late `rnd_ready` is ignored.
